udp_csum_accum: RTL

Streaming ones-complement checksum accumulator for the UDP/IP framer path. It sits directly upstream of the 16-bit end-around-carry adder and instantiates it as its arithmetic element. Each accepted 16-bit payload/header word is folded into a running sum seeded with a caller-supplied pseudo-header partial sum. On end-of-frame it presents the final inverted checksum and the word count, held until acknowledged.

---
 rtl/udp_csum_accum_pkg.sv | 20 ++
 rtl/udp_csum_accum_eac_add.sv | 25 ++
 rtl/udp_csum_accum.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/udp_csum_accum_pkg.sv
// ---------------------------------------------------------------------------
// udp_csum_accum_pkg
// Shared definitions for the streaming UDP/IP checksum accumulator.
//   state_t        : accumulator FSM encoding (IDLE / ACCUM / HOLD)
//   CSUM_W         : checksum / data word width (16 only)
//   ZERO_SUB_VALUE : value sent in place of an all-zero checksum when the
//                    UDP_CSUM_ZERO_SUB_EN build option is defined
// ---------------------------------------------------------------------------
package udp_csum_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int          CSUM_W         = 16;
    localparam logic [15:0] ZERO_SUB_VALUE = 16'hFFFF;

endpackage

// File: rtl/udp_csum_accum_eac_add.sv
// ---------------------------------------------------------------------------
// udp_csum_accum_eac_add
// Combinational ones-complement (end-around-carry) adder.
//   a, b : WIDTH-bit operands
//   sum  : a + b with the carry out folded back into bit 0
// The folded add cannot carry a second time: the largest raw sum is
// 2*(2^W-1) = 2^W + (2^W-2), whose low part plus one still fits in W bits.
// -0 (all ones) is not normalised.
// ---------------------------------------------------------------------------
module udp_csum_accum_eac_add
    import udp_csum_accum_pkg::*;
#(
    parameter int WIDTH = CSUM_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] raw_sum;

    assign raw_sum = {1'b0, a} + {1'b0, b};
    assign sum     = raw_sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, raw_sum[WIDTH]};

endmodule

// File: rtl/udp_csum_accum.sv
// ---------------------------------------------------------------------------
// udp_csum_accum
// Streaming ones-complement checksum accumulator. Each accepted 16-bit word
// is folded into a running sum seeded with a pseudo-header partial sum taken
// on the SOF beat. After the EOF beat the inverted sum and the word count are
// presented and held until acknowledged.
//
// Build option: UDP_CSUM_ZERO_SUB_EN -- when defined, a computed checksum of
// 0x0000 is replaced with 0xFFFF (UDP "no checksum" avoidance).
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   seed_i         : pseudo-header partial sum, sampled on the SOF beat
//   data_i         : stream word
//   sof_i, eof_i   : first / last word of frame
//   src_rdy_i      : upstream word valid
//   dst_rdy_o      : block accepts a word (low only while a result is held)
//   csum_o, len_o  : final checksum and word count, stable while held
//   csum_valid_o   : result held and valid
//   csum_ack_i     : consumer takes the result
//   abort_o        : one-cycle pulse after an SOF arrives mid-frame
// ---------------------------------------------------------------------------
module udp_csum_accum
    import udp_csum_accum_pkg::*;
#(
    parameter int WIDTH = CSUM_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             sof_i,
    input  logic             eof_i,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [WIDTH-1:0] csum_o,
    output logic [CNT_W-1:0] len_o,
    output logic             csum_valid_o,
    input  logic             csum_ack_i,
    output logic             abort_o
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] csum_reg, csum_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic             abort_reg, abort_next;

    logic             accept;
    logic             frame_beat;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] csum_calc;
    logic [WIDTH-1:0] csum_final;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] beat_cnt;

    assign dst_rdy_o    = (state_reg != ST_HOLD);
    assign csum_valid_o = (state_reg == ST_HOLD);
    assign accept       = src_rdy_i & dst_rdy_o;

    // A beat belongs to a frame if it opens one or continues one; stray
    // non-SOF beats in IDLE (EOF included) are consumed and dropped.
    assign frame_beat   = accept & (sof_i | (state_reg == ST_ACCUM));

    // SOF restarts the sum from the seed, whether or not a frame was open.
    assign add_a        = sof_i ? seed_i : acc_reg;

    udp_csum_accum_eac_add #(
        .WIDTH (WIDTH)
    ) u_eac_add (
        .a   (add_a),
        .b   (data_i),
        .sum (add_sum)
    );

    assign cnt_inc   = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign beat_cnt  = sof_i ? CNT_W'(1) : cnt_inc;
    assign csum_calc = ~add_sum;

`ifdef UDP_CSUM_ZERO_SUB_EN
    assign csum_final = (csum_calc == '0) ? ZERO_SUB_VALUE : csum_calc;
`else
    assign csum_final = csum_calc;
`endif

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        csum_next  = csum_reg;
        len_next   = len_reg;
        abort_next = accept & sof_i & (state_reg == ST_ACCUM);

        case (state_reg)
            ST_IDLE, ST_ACCUM: begin
                if (frame_beat) begin
                    acc_next = add_sum;
                    cnt_next = beat_cnt;
                    if (eof_i) begin
                        state_next = ST_HOLD;
                        csum_next  = csum_final;
                        len_next   = beat_cnt;
                    end else begin
                        state_next = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                if (csum_ack_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            csum_reg  <= '0;
            len_reg   <= '0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            csum_reg  <= csum_next;
            len_reg   <= len_next;
            abort_reg <= abort_next;
        end
    end

    assign csum_o  = csum_reg;
    assign len_o   = len_reg;
    assign abort_o = abort_reg;

endmodule
